// File: rtl/exe_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit for the EXE stage; owns HI/LO.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
module exe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Rs_data,
  input  logic [WIDTH-1:0] Rt_data,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall_ID,
  output logic             Done,
  output logic             Div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    cond_neg2 = neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;
  logic                 is_div_r;
  logic                 neg_hi_r;
  logic                 neg_lo_r;
  logic                 dbz_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 dbz_out_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 signed_s;
  logic                 sign_xor_s;
  logic [WIDTH-1:0]     mag_a_s;
  logic [WIDTH-1:0]     mag_b_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       rem_sh_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   step_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // Operand decode, one iteration step of each algorithm, and the final sign fix-up.
  always_comb begin
    signed_s   = ~Op[0];
    sign_xor_s = signed_s & (Rs_data[WIDTH-1] ^ Rt_data[WIDTH-1]);
    mag_a_s    = cond_neg(Rs_data, signed_s & Rs_data[WIDTH-1]);
    mag_b_s    = cond_neg(Rt_data, signed_s & Rt_data[WIDTH-1]);

    // Multiplier sits in the low half and is consumed LSB first.
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Remainder in the high half, dividend/quotient shifting through the low half.
    rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s   = (rem_sh_s >= {1'b0, opnd_r});
    div_diff_s = rem_sh_s[WIDTH-1:0] - opnd_r;
    if (div_ge_s) begin
      div_next_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end

    if (state_r == DIV) begin
      step_s = div_next_s;
    end else begin
      step_s = mul_next_s;
    end

    prod_s = cond_neg2(acc_r, neg_hi_r);
    rem_s  = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_hi_r);
    if (dbz_r) begin
      quo_s = {WIDTH{1'b1}};
    end else begin
      quo_s = cond_neg(acc_r[WIDTH-1:0], neg_lo_r);
    end
  end

  // Control FSM, datapath registers and architectural HI/LO, all on the falling edge.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_hi_r  <= 1'b0;
      neg_lo_r  <= 1'b0;
      dbz_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start && !Flush) begin
            case (Op)
              OP_MULT, OP_MULTU: begin
                acc_r    <= {{WIDTH{1'b0}}, mag_b_s};
                opnd_r   <= mag_a_s;
                neg_hi_r <= sign_xor_s;
                neg_lo_r <= sign_xor_s;
                is_div_r <= 1'b0;
                dbz_r    <= 1'b0;
                cnt_r    <= {CW{1'b0}};
                busy_r   <= 1'b1;
                state_r  <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
                opnd_r   <= mag_b_s;
                neg_hi_r <= signed_s & Rs_data[WIDTH-1];
                neg_lo_r <= sign_xor_s;
                is_div_r <= 1'b1;
                dbz_r    <= (Rt_data == {WIDTH{1'b0}});
                cnt_r    <= {CW{1'b0}};
                busy_r   <= 1'b1;
                state_r  <= DIV;
              end
              OP_MTHI: hi_r <= Rs_data;
              OP_MTLO: lo_r <= Rs_data;
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        MUL, DIV: begin
          if (Flush) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(WIDTH - 1)) begin
              state_r <= FIX;
            end else begin
              state_r <= state_r;
            end
          end
        end
        FIX: begin
          // A squash landing on the write cycle still wins: HI/LO stay untouched.
          if (Flush) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            if (is_div_r) begin
              hi_r <= rem_s;
              lo_r <= quo_s;
            end else begin
              hi_r <= prod_s[2*WIDTH-1:WIDTH];
              lo_r <= prod_s[WIDTH-1:0];
            end
            done_r    <= 1'b1;
            dbz_out_r <= dbz_r;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign Busy        = busy_r;
  assign Stall_ID    = busy_r;
  assign Done        = done_r;
  assign Div_by_zero = dbz_out_r;
  assign HI          = hi_r;
  assign LO          = lo_r;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: a 64-bit reference model predicts HI/LO/Div_by_zero
// for every issued mul/div; a monitor pops and compares on each Done pulse.
module tb_exe_muldiv_unit;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic [2:0]    Op = 3'b110;
  logic [W-1:0]  Rs_data = '0;
  logic [W-1:0]  Rt_data = '0;
  logic          Flush = 1'b0;
  logic          Busy;
  logic          Stall_ID;
  logic          Done;
  logic          Div_by_zero;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  typedef struct packed {
    logic          dbz;
    logic [31:0]   hi;
    logic [31:0]   lo;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [31:0]   hi_m = '0;
  logic [31:0]   lo_m = '0;
  int            n_tests = 0;
  int            n_fail = 0;

  exe_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .Flush(Flush),
    .Busy(Busy), .Stall_ID(Stall_ID), .Done(Done), .Div_by_zero(Div_by_zero),
    .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'b001: begin p = {32'h0, a} * {32'h0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'b010, 3'b011: begin
        if (b == 32'h0) begin
          e.dbz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else if (op == 3'b010) begin
          q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Every Done pulse must match the oldest outstanding prediction.
  always @(posedge Clk) begin
    if (Rst_n && Done) begin
      if (sb_q.size() == 0) begin
        check_val("done_spurious", {63'h0, Done}, 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("res_hi", {32'h0, HI}, {32'h0, mon_e.hi});
        check_val("res_lo", {32'h0, LO}, {32'h0, mon_e.lo});
        check_val("res_dbz", {63'h0, Div_by_zero}, {63'h0, mon_e.dbz});
        hi_m = mon_e.hi;
        lo_m = mon_e.lo;
      end
    end
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    Start   = 1'b1;
    Op      = op;
    Rs_data = a;
    Rt_data = b;
    if (push) sb_q.push_back(model(op, a, b));
    step();
    Start = 1'b0;
    Op    = 3'b110;
  endtask

  task automatic wait_done(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      step();
    end
    check_val(tag, n, exp_cycles);
    check_val({tag, "_done"}, {63'h0, Done}, 64'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    #12;
    check_val("rst_busy", {63'h0, Busy}, 64'h0);
    check_val("rst_stall", {63'h0, Stall_ID}, 64'h0);
    check_val("rst_done", {63'h0, Done}, 64'h0);
    check_val("rst_hilo", {HI, LO}, 64'h0);
    Rst_n = 1'b1;
    step();

    issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
    check_val("busy_set", {63'h0, Busy}, 64'h1);
    check_val("stall_set", {63'h0, Stall_ID}, 64'h1);
    wait_done(33, "mult_lat");
    issue(3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
    wait_done(33, "multu_lat");
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    wait_done(33, "div_lat");
    issue(3'b011, 32'd100, 32'd7, 1'b1);
    wait_done(33, "divu_b2b_lat");
    issue(3'b011, 32'd5, 32'd0, 1'b1);
    wait_done(33, "divu_dbz_lat");
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(33, "div_ovf_lat");
    issue(3'b010, 32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_done(33, "div_dbz_lat");
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 2) ? 32'h0 : $urandom;
      issue(rop, ra, rb, 1'b1);
      wait_done(33, "rand_lat");
    end
    step();
    step();

    issue(3'b100, 32'h1234_5678, 32'h0, 1'b0);
    check_val("mthi_hi", {32'h0, HI}, 64'h1234_5678);
    check_val("mthi_busy", {63'h0, Busy}, 64'h0);
    issue(3'b101, 32'h9ABC_DEF0, 32'h0, 1'b0);
    check_val("mtlo_lo", {32'h0, LO}, 64'h9ABC_DEF0);
    check_val("mtlo_hi_kept", {32'h0, HI}, 64'h1234_5678);
    check_val("mtlo_busy", {63'h0, Busy}, 64'h0);
    check_val("mtlo_done", {63'h0, Done}, 64'h0);
    hi_m = 32'h1234_5678;
    lo_m = 32'h9ABC_DEF0;

    issue(3'b000, 32'h0000_0123, 32'hFFFF_FF00, 1'b1);
    issue(3'b100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check_val("mthi_busy_hold", {32'h0, HI}, {32'h0, hi_m});
    wait_done(32, "mult_mthi_lat");
    step();
    step();
    check_val("mthi_ignored", {32'h0, HI}, {32'h0, hi_m});

    issue(3'b000, 32'h0000_0007, 32'h0000_0009, 1'b0);
    repeat (9) step();
    check_val("flush_mid_busy", {63'h0, Busy}, 64'h1);
    check_val("flush_mid_hold", {HI, LO}, {hi_m, lo_m});
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check_val("flush_busy", {63'h0, Busy}, 64'h0);
    check_val("flush_hilo", {HI, LO}, {hi_m, lo_m});
    repeat (36) step();
    check_val("flush_no_done", {63'h0, Done}, 64'h0);
    check_val("flush_hilo_late", {HI, LO}, {hi_m, lo_m});

    Flush = 1'b1;
    issue(3'b100, 32'hCAFE_F00D, 32'h0, 1'b0);
    check_val("flush_mthi", {32'h0, HI}, {32'h0, hi_m});
    issue(3'b011, 32'd50, 32'd5, 1'b0);
    Flush = 1'b0;
    check_val("flush_start_busy", {63'h0, Busy}, 64'h0);

    issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    repeat (9) step();
    #2;
    Rst_n = 1'b0;
    #1;
    check_val("arst_busy", {63'h0, Busy}, 64'h0);
    check_val("arst_stall", {63'h0, Stall_ID}, 64'h0);
    check_val("arst_flags", {62'h0, Done, Div_by_zero}, 64'h0);
    check_val("arst_hilo", {HI, LO}, 64'h0);
    #2;
    Rst_n = 1'b1;
    step();
    check_val("arst_post_busy", {63'h0, Busy}, 64'h0);
    check_val("sb_empty", sb_q.size(), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EXE stage, downstream of the ID/EXE pipeline register.
- Consumes the decoded op and the Rs/Rt operands launched by ID/EXE, and owns the architectural HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU over WIDTH+1 cycles; handles MTHI/MTLO in a single cycle.
- Drives Stall_ID back to the front end so ID/EXE holds while an operation is in flight.

Parameters:
- WIDTH, 32: operand width; also the number of iteration cycles.

Ports:
- Clk  in  1  clock; all state updates on falling edge, consistent with the pipeline registers
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  op valid from ID/EXE for the current cycle
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP
- Rs_data  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- Rt_data  in  WIDTH  multiplier / divisor
- Flush  in  1  abort in-flight op (branch/jump squash)
- Busy  out  1  operation in progress
- Stall_ID  out  1  freeze request to the PC, IF/ID and ID/EXE registers; equals Busy
- Done  out  1  one-cycle pulse when HI/LO are written by a mul/div
- Div_by_zero  out  1  qualifies Done; divisor was zero
- HI  out  WIDTH  HI register, read directly by MFHI
- LO  out  WIDTH  LO register, read directly by MFLO

Behaviour:
- Reset (Rst_n low, asynchronous, any state):
  - state=IDLE, HI=0, LO=0, Busy=0, Done=0, Div_by_zero=0, iteration counter=0.
  - Takes effect immediately; an in-flight op is discarded.
- State machine: IDLE, MUL, DIV, FIX.
- IDLE:
  - Start=1 with a mul/div op at falling edge E0:
    - Latch operands. For signed ops, convert to magnitudes and record result signs.
    - Quotient sign = Rs[msb]^Rt[msb]; remainder sign = Rs[msb]; product sign = Rs[msb]^Rt[msb].
    - Clear counter, set Busy=1, go to MUL or DIV.
  - Start=1 with MTHI/MTLO: write HI or LO with Rs_data at that edge. Busy stays 0, Done stays 0.
  - NOP, or Start=0: no change.
- MUL: shift-add, one partial-product bit per edge, 2*WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per edge, WIDTH-bit remainder.
- Iteration count: counter increments each edge. Exit to FIX after WIDTH iterations (edges E1..E32 for WIDTH=32).
- FIX (edge E33):
  - Apply two's-complement sign correction.
  - Write HI/LO:
    - mul: HI=upper half, LO=lower half.
    - div: LO=quotient, HI=remainder.
  - Set Done=1, Busy=0, return to IDLE.
- Done and Div_by_zero are high for exactly the cycle after E33 and are cleared at the next edge.
  - A Start at that edge is accepted (back-to-back issue).
- Latency: WIDTH+1 falling edges from acceptance to HI/LO update. Busy/Stall_ID is high for WIDTH+1 cycles.
- Start while Busy=1: ignored, including MTHI/MTLO. The upstream hazard logic holds the instruction via Stall_ID.
- Divide by zero:
  - Full latency is still taken.
  - Result HI=Rs_data (dividend as latched), LO=all ones.
  - Div_by_zero=1 alongside Done.
  - Same result for DIV and DIVU.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no error flag.
  - This falls out naturally from magnitude arithmetic; no special-case path.
- Flush:
  - Flush=1 at an edge while Busy: return to IDLE, Busy=0, HI/LO unchanged, Done not pulsed.
  - Flush=1 together with Start in IDLE: Start is ignored, including MTHI/MTLO.
  - Flush has priority over the FIX write when both coincide.
- HI/LO change only at the FIX edge, at MTHI/MTLO, or at reset; never mid-iteration.

Test Plan:
- MULT Rs=0xFFFFFFFD, Rt=0x00000007 -> after 33 edges: HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done one cycle; Busy high 33 cycles.
- MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV Rs=0xFFFFFFF9 (-7), Rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then back-to-back DIVU 100/7 issued on the Done cycle -> LO=0x0000000E, HI=0x00000002.
- DIVU Rs=5, Rt=0 -> HI=0x00000005, LO=0xFFFFFFFF, Div_by_zero=1 with Done. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, Div_by_zero=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive idle cycles -> HI/LO updated one edge each, Busy never asserted. MTHI issued while Busy -> HI unchanged.
- MULT in progress, Flush at iteration 10 -> Busy=0 next edge, HI/LO keep prior values, no Done. Repeat with Rst_n pulsed low at iteration 10 -> all outputs 0 immediately, without waiting for a clock edge.
